// File: rtl/binary_qkv_engine.sv
// binary_qkv_engine: binary-weight (+1/-1) Q/K/V projection engine.
// Streams IN_DIM signed activations in, accumulates 3*OUT_DIM dot products
// against a per-block weight store, then drains one column per handshake.
// Optional build macro QKV_SATURATE_EN: when defined, outputs saturate to the
// DATA_W range; when undefined, outputs wrap (low DATA_W bits).
module binary_qkv_engine #(
  parameter  int DATA_W   = 16,
  parameter  int IN_DIM   = 30,
  parameter  int OUT_DIM  = 8,
  parameter  int N_BLOCKS = 4,
  parameter  int BLK_W    = 2,
  localparam int ACC_W    = DATA_W + $clog2(IN_DIM),
  localparam int IDX_W    = $clog2(OUT_DIM),
  localparam int ROW_W    = 3*OUT_DIM,
  localparam int AW       = $clog2(N_BLOCKS*IN_DIM)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [BLK_W-1:0]         block_sel,
  input  logic signed [DATA_W-1:0] data_in,
  input  logic                     data_in_valid,
  output logic                     data_in_ready,
  input  logic                     w_wr_en,
  input  logic [AW-1:0]            w_wr_addr,
  input  logic [ROW_W-1:0]         w_wr_data,
  output logic signed [DATA_W-1:0] q_out,
  output logic signed [DATA_W-1:0] k_out,
  output logic signed [DATA_W-1:0] v_out,
  output logic [IDX_W-1:0]         out_idx,
  output logic                     out_valid,
  output logic                     out_last,
  input  logic                     out_ready,
  output logic                     busy
);

  localparam int DEPTH = N_BLOCKS*IN_DIM;
  localparam int CNT_W = $clog2(IN_DIM+1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN} state_t;

  state_t                   state;
  logic                     ready_r;
  logic                     valid_r;
  logic                     busy_r;
  logic [BLK_W-1:0]         blk_r;
  logic [CNT_W-1:0]         elem_cnt;
  logic [IDX_W-1:0]         idx_r;

  logic [ROW_W-1:0]         wmem [DEPTH];

  logic signed [ACC_W-1:0]  acc_q [OUT_DIM];
  logic signed [ACC_W-1:0]  acc_k [OUT_DIM];
  logic signed [ACC_W-1:0]  acc_v [OUT_DIM];

  logic                     accept;
  logic                     drain_hs;
  logic                     last_hs;
  logic [BLK_W-1:0]         blk_in;
  logic [BLK_W-1:0]         rd_blk;
  logic [CNT_W-1:0]         rd_elem;
  logic [AW-1:0]            rd_addr;
  logic [ROW_W-1:0]         rd_row;
  logic signed [ACC_W-1:0]  act_ext;
  logic signed [ACC_W-1:0]  act_neg;

  // Reduce an accumulator to the output width (clamp or wrap by build option).
  function automatic logic signed [DATA_W-1:0] reduce_acc(input logic signed [ACC_W-1:0] a);
`ifdef QKV_SATURATE_EN
    // In range when every bit above the output sign bit matches it.
    if ((&a[ACC_W-1:DATA_W-1]) || !(|a[ACC_W-1:DATA_W-1]))
      return a[DATA_W-1:0];
    else if (a[ACC_W-1])
      return {1'b1, {(DATA_W-1){1'b0}}};
    else
      return {1'b0, {(DATA_W-1){1'b1}}};
`else
    return a[DATA_W-1:0];
`endif
  endfunction

  // Handshake decode and weight-row addressing; the first element of a vector
  // reads with the live block_sel because blk_r is only loaded on that accept.
  always_comb begin
    accept   = data_in_valid & ready_r;
    drain_hs = valid_r & out_ready;
    last_hs  = drain_hs & (idx_r == IDX_W'(OUT_DIM-1));
    blk_in   = (int'(block_sel) >= N_BLOCKS) ? '0 : block_sel;
    rd_blk   = (state == S_IDLE) ? blk_in : blk_r;
    rd_elem  = (state == S_IDLE) ? '0 : elem_cnt;
    rd_addr  = AW'(int'(rd_blk) * IN_DIM + int'(rd_elem));
    rd_row   = wmem[rd_addr];
    act_ext  = ACC_W'(data_in);
    act_neg  = -act_ext;
  end

  // Weight store: not reset, writable only while idle, out-of-range writes dropped.
  always_ff @(posedge clk) begin
    if (w_wr_en && (state == S_IDLE) && (int'(w_wr_addr) < DEPTH))
      wmem[w_wr_addr] <= w_wr_data;
  end

  // Control FSM: vector accept, element counting, column drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ready_r  <= 1'b1;
      valid_r  <= 1'b0;
      busy_r   <= 1'b0;
      blk_r    <= '0;
      elem_cnt <= '0;
      idx_r    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            blk_r    <= blk_in;
            elem_cnt <= CNT_W'(1);
            busy_r   <= 1'b1;
            if (IN_DIM == 1) begin
              state   <= S_DRAIN;
              ready_r <= 1'b0;
              valid_r <= 1'b1;
            end else begin
              state   <= S_ACCUM;
            end
          end
        end
        S_ACCUM: begin
          if (accept) begin
            elem_cnt <= elem_cnt + CNT_W'(1);
            if (elem_cnt == CNT_W'(IN_DIM-1)) begin
              state   <= S_DRAIN;
              ready_r <= 1'b0;
              valid_r <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (last_hs) begin
            state    <= S_IDLE;
            ready_r  <= 1'b1;
            valid_r  <= 1'b0;
            busy_r   <= 1'b0;
            elem_cnt <= '0;
            idx_r    <= '0;
          end else if (drain_hs) begin
            idx_r    <= idx_r + IDX_W'(1);
          end
        end
        default: begin
          state   <= S_IDLE;
          ready_r <= 1'b1;
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Accumulators: add or subtract the activation per weight bit; cleared on the final drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < OUT_DIM; j++) begin
        acc_q[j] <= '0;
        acc_k[j] <= '0;
        acc_v[j] <= '0;
      end
    end else if (last_hs) begin
      for (int j = 0; j < OUT_DIM; j++) begin
        acc_q[j] <= '0;
        acc_k[j] <= '0;
        acc_v[j] <= '0;
      end
    end else if (accept) begin
      for (int j = 0; j < OUT_DIM; j++) begin
        acc_q[j] <= acc_q[j] + (rd_row[j]           ? act_ext : act_neg);
        acc_k[j] <= acc_k[j] + (rd_row[OUT_DIM+j]   ? act_ext : act_neg);
        acc_v[j] <= acc_v[j] + (rd_row[2*OUT_DIM+j] ? act_ext : act_neg);
      end
    end
  end

  // Output column mux; zero outside the drain phase.
  always_comb begin
    q_out         = valid_r ? reduce_acc(acc_q[idx_r]) : '0;
    k_out         = valid_r ? reduce_acc(acc_k[idx_r]) : '0;
    v_out         = valid_r ? reduce_acc(acc_v[idx_r]) : '0;
    out_idx       = idx_r;
    out_valid     = valid_r;
    out_last      = valid_r & (idx_r == IDX_W'(OUT_DIM-1));
    data_in_ready = ready_r;
    busy          = busy_r;
  end

endmodule

// File: tb/tb_binary_qkv_engine.sv
// tb_binary_qkv_engine: directed plus randomized bench for binary_qkv_engine
// with a queue-based dot-product reference model and a per-cycle comparator.
module tb_binary_qkv_engine;

  localparam int DATA_W   = 16;
  localparam int IN_DIM   = 30;
  localparam int OUT_DIM  = 8;
  localparam int N_BLOCKS = 4;
  localparam int BLK_W    = 2;
  localparam int IDX_W    = 3;
  localparam int ROW_W    = 24;
  localparam int AW       = 7;
  localparam int DEPTH    = N_BLOCKS*IN_DIM;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [BLK_W-1:0]  block_sel = '0;
  logic [DATA_W-1:0] data_in = '0;
  logic              data_in_valid = 1'b0;
  logic              data_in_ready;
  logic              w_wr_en = 1'b0;
  logic [AW-1:0]     w_wr_addr = '0;
  logic [ROW_W-1:0]  w_wr_data = '0;
  logic [DATA_W-1:0] q_out, k_out, v_out;
  logic [IDX_W-1:0]  out_idx;
  logic              out_valid, out_last;
  logic              out_ready = 1'b0;
  logic              busy;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  binary_qkv_engine #(.DATA_W(DATA_W), .IN_DIM(IN_DIM), .OUT_DIM(OUT_DIM),
                      .N_BLOCKS(N_BLOCKS), .BLK_W(BLK_W)) dut (
    .clk(clk), .rst_n(rst_n), .block_sel(block_sel), .data_in(data_in),
    .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
    .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data),
    .q_out(q_out), .k_out(k_out), .v_out(v_out), .out_idx(out_idx),
    .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic longint sx(input logic [DATA_W-1:0] x);
    return longint'($signed(x));
  endfunction

  // Reference reduction from the specification's arithmetic rules.
  function automatic longint red(input longint s);
`ifdef QKV_SATURATE_EN
    if (s > 32767) return 32767;
    if (s < -32768) return -32768;
    return s;
`else
    longint t;
    t = s & 64'hFFFF;
    if (t >= 32768) t = t - 65536;
    return t;
`endif
  endfunction

  // ---------------- reference model ----------------
  int               m_phase = 0;   // 0 idle, 1 collecting, 2 draining
  int               m_blk = 0;
  int               m_idx = 0;
  logic [ROW_W-1:0] mw [DEPTH];
  logic [ROW_W-1:0] m_rows [$];
  longint           m_data [$];
  longint           m_sum [3][OUT_DIM];
  bit               m_acc, m_wr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_idx = 0;
      m_rows.delete();
      m_data.delete();
    end else begin
      m_acc = data_in_valid && (m_phase != 2);
      m_wr  = w_wr_en && (m_phase == 0) && (int'(w_wr_addr) < DEPTH);
      if (m_acc) begin
        if (m_phase == 0) m_blk = (int'(block_sel) >= N_BLOCKS) ? 0 : int'(block_sel);
        m_rows.push_back(mw[m_blk*IN_DIM + m_rows.size()]);
        m_data.push_back(sx(data_in));
        m_phase = 1;
        if (m_rows.size() == IN_DIM) begin
          for (int p = 0; p < 3; p++)
            for (int j = 0; j < OUT_DIM; j++) begin
              longint s;
              s = 0;
              for (int e = 0; e < IN_DIM; e++)
                s += m_rows[e][p*OUT_DIM+j] ? m_data[e] : -m_data[e];
              m_sum[p][j] = s;
            end
          m_phase = 2;
          m_idx = 0;
        end
      end else if (m_phase == 2 && out_ready) begin
        if (m_idx == OUT_DIM-1) begin
          m_phase = 0;
          m_idx = 0;
          m_rows.delete();
          m_data.delete();
        end else begin
          m_idx++;
        end
      end
      if (m_wr) mw[w_wr_addr] = w_wr_data;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check("cmp_ready", data_in_ready, m_phase != 2);
      check("cmp_valid", out_valid, m_phase == 2);
      check("cmp_busy",  busy, m_phase != 0);
      check("cmp_idx",   out_idx, (m_phase == 2) ? m_idx : 0);
      check("cmp_last",  out_last, (m_phase == 2) && (m_idx == OUT_DIM-1));
      check("cmp_q", sx(q_out), (m_phase == 2) ? red(m_sum[0][m_idx]) : 0);
      check("cmp_k", sx(k_out), (m_phase == 2) ? red(m_sum[1][m_idx]) : 0);
      check("cmp_v", sx(v_out), (m_phase == 2) ? red(m_sum[2][m_idx]) : 0);
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [DATA_W-1:0] vec [IN_DIM];
  logic [DATA_W-1:0] cap_q [OUT_DIM];
  logic [DATA_W-1:0] cap_k [OUT_DIM];
  logic [DATA_W-1:0] cap_v [OUT_DIM];
  logic [IDX_W-1:0]  cap_idx [OUT_DIM];
  bit                cap_last [OUT_DIM];

  task automatic write_row(input int addr, input logic [ROW_W-1:0] data);
    w_wr_en = 1'b1;
    w_wr_addr = AW'(addr);
    w_wr_data = data;
    @(posedge clk); #1;
    w_wr_en = 1'b0;
  endtask

  task automatic send_vec(input int blk0, input int blkr, input int n, input bit gaps, input bit wr_first);
    int guard;
    bit ok;
    for (int e = 0; e < n; e++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        data_in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
      data_in = vec[e];
      if (e == 0) block_sel = BLK_W'(blk0);
      else if (blkr < 0) block_sel = BLK_W'($urandom);
      else block_sel = BLK_W'(blkr);
      data_in_valid = 1'b1;
      if (e == 0 && wr_first) begin
        w_wr_en = 1'b1;
        w_wr_addr = AW'($urandom_range(0, 127));
        w_wr_data = ROW_W'($urandom);
      end
      guard = 0;
      ok = 1'b0;
      while (!ok && guard < 100) begin
        @(negedge clk);
        ok = data_in_ready;
        @(posedge clk); #1;
        w_wr_en = 1'b0;
        guard++;
      end
      if (!ok) check("send_timeout", 0, 1);
    end
    data_in_valid = 1'b0;
  endtask

  task automatic drain(input int stall_idx, input int stall_n, input longint hold_q, input bit rnd);
    int col, guard, st;
    col = 0; guard = 0; st = 0;
    while (col < OUT_DIM && guard < 300) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      else if (col == stall_idx && st < stall_n) begin
        out_ready = 1'b0;
        w_wr_en = 1'b1;
        w_wr_addr = AW'(st);
        w_wr_data = '0;
      end else out_ready = 1'b1;
      @(negedge clk);
      if (out_valid && out_ready) begin
        cap_q[col] = q_out; cap_k[col] = k_out; cap_v[col] = v_out;
        cap_idx[col] = out_idx; cap_last[col] = out_last;
        col++;
      end else if (!rnd && col == stall_idx && st < stall_n) begin
        check("bp_hold_q", sx(q_out), hold_q);
        check("bp_valid", out_valid, 1);
        check("bp_idx", out_idx, stall_idx);
        check("bp_ready", data_in_ready, 0);
        st++;
      end
      @(posedge clk); #1;
      w_wr_en = 1'b0;
      guard++;
    end
    out_ready = 1'b0;
    if (col < OUT_DIM) check("drain_timeout", col, OUT_DIM);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    repeat (3) @(posedge clk); #1;
    check("rst_ready", data_in_ready, 1);
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_idx", out_idx, 0);
    check("rst_q", sx(q_out), 0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #1;

    // All-positive sum: block 0 all +1, inputs 1..30.
    for (int e = 0; e < IN_DIM; e++) write_row(e, '1);
    for (int e = 0; e < IN_DIM; e++) vec[e] = DATA_W'(e + 1);
    send_vec(0, 0, IN_DIM, 0, 0);
    check("t1_lat_valid", out_valid, 1);
    drain(-1, 0, 0, 0);
    check("t1_ready_back", data_in_ready, 1);
    for (int j = 0; j < OUT_DIM; j++) begin
      check("t1_q", sx(cap_q[j]), 465);
      check("t1_v", sx(cap_v[j]), 465);
      check("t1_idx", cap_idx[j], j);
    end
    check("t1_k0", sx(cap_k[0]), 465);
    check("t1_last7", cap_last[7], 1);
    check("t1_last6", cap_last[6], 0);

    // Mixed weights on block 1.
    for (int e = 0; e < IN_DIM; e++)
      write_row(IN_DIM + e, {8'h00, 7'h7F, 1'((e % 2) == 0), 8'hFF});
    for (int e = 0; e < IN_DIM; e++) vec[e] = 16'd100;
    send_vec(1, 1, IN_DIM, 0, 0);
    drain(-1, 0, 0, 0);
    check("t2_q0", sx(cap_q[0]), 3000);
    check("t2_q5", sx(cap_q[5]), 3000);
    check("t2_v0", sx(cap_v[0]), -3000);
    check("t2_v7", sx(cap_v[7]), -3000);
    check("t2_k0", sx(cap_k[0]), 0);
    check("t2_k1", sx(cap_k[1]), 3000);

    // Overflow: +1 weights with 0x7FFF, then -1 weights (block 3) with 0x8000.
    for (int e = 0; e < IN_DIM; e++) vec[e] = 16'h7FFF;
    send_vec(0, 0, IN_DIM, 0, 0);
    drain(-1, 0, 0, 0);
`ifdef QKV_SATURATE_EN
    check("t3_q_pos", longint'(cap_q[0]), 'h7FFF);
`else
    check("t3_q_pos", longint'(cap_q[0]), 'hFFE2);
`endif
    for (int e = 0; e < IN_DIM; e++) write_row(3*IN_DIM + e, '0);
    for (int e = 0; e < IN_DIM; e++) vec[e] = 16'h8000;
    send_vec(3, 3, IN_DIM, 0, 0);
    drain(-1, 0, 0, 0);
`ifdef QKV_SATURATE_EN
    check("t3_q_neg", longint'(cap_q[2]), 'h7FFF);
`else
    check("t3_q_neg", longint'(cap_q[2]), 'h0000);
`endif

    // Backpressure at idx 3 with write pulses into block 0 during drain.
    for (int e = 0; e < IN_DIM; e++) vec[e] = DATA_W'(e + 1);
    send_vec(0, 0, IN_DIM, 0, 0);
    drain(3, 5, 465, 0);
    check("t4_q3", sx(cap_q[3]), 465);
    check("t4_q4", sx(cap_q[4]), 465);

    // Mid-vector reset after 10 accepts, then a full vector on intact weights.
    send_vec(0, 0, 10, 0, 0);
    check("t5_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    check("t5_busy", busy, 0);
    check("t5_valid", out_valid, 0);
    check("t5_q", sx(q_out), 0);
    check("t5_ready", data_in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_vec(0, 0, IN_DIM, 0, 0);
    drain(-1, 0, 0, 0);
    check("t5_q0", sx(cap_q[0]), 465);
    check("t5_k7", sx(cap_k[7]), 465);

    // Block select sampled on the first element only.
    for (int e = 0; e < IN_DIM; e++) write_row(2*IN_DIM + e, '1);
    for (int e = 0; e < IN_DIM; e++) write_row(e, '0);
    for (int e = 0; e < IN_DIM; e++) vec[e] = 16'd1;
    send_vec(2, 0, IN_DIM, 0, 0);
    drain(-1, 0, 0, 0);
    check("t6_q", sx(cap_q[1]), 30);
    check("t6_k", sx(cap_k[4]), 30);
    check("t6_v", sx(cap_v[7]), 30);

    // Randomized vectors, weights, gaps, backpressure and coincident writes.
    for (int a = 0; a < DEPTH; a++) write_row(a, ROW_W'($urandom));
    for (int a = DEPTH; a < 128; a++) write_row(a, ROW_W'($urandom));
    for (int t = 0; t < 25; t++) begin
      for (int e = 0; e < IN_DIM; e++) vec[e] = DATA_W'($urandom);
      if ($urandom_range(0, 3) == 0)
        write_row($urandom_range(0, 127), ROW_W'($urandom));
      send_vec($urandom_range(0, N_BLOCKS-1), -1, IN_DIM, 1, 1'($urandom_range(0, 1)));
      drain(-1, 0, 0, 1);
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
